// File: rtl/conv_window_router.sv
// conv_window_router: im2col address walker between activation SRAM and PE array.
// Walks oy/ox/ky/kx/c with stride and zero padding, issues one SRAM read (or a
// zero pad word) per element and streams them in window order through a
// 2-entry FIFO with window/frame markers.
//
// state | meaning
// IDLE  | waiting for i_start, config captured on acceptance
// RUN   | issuing one element per cycle while fewer than 2 are outstanding
// DRAIN | all elements issued, waiting for the FIFO to empty
// DONE  | one-cycle completion pulse
module conv_window_router #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int K_WIDTH    = 3,
    parameter int C_WIDTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_o_size,
    input  logic [K_WIDTH-1:0]    i_k_size,
    input  logic [1:0]            i_stride,
    input  logic [1:0]            i_pad,
    input  logic [C_WIDTH-1:0]    i_c_words,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last_win,
    output logic                  o_last_all,
    output logic                  o_busy,
    output logic                  o_done
);

    // Signed image coordinates need headroom for oy*stride+ky and a negative pad offset.
    localparam int SW = ADDR_WIDTH + 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] start_r, i_size_r, o_size_r;
    logic [K_WIDTH-1:0]    k_r;
    logic [1:0]            stride_r, pad_r;
    logic [C_WIDTH-1:0]    c_words_r;

    logic [ADDR_WIDTH-1:0] oy, ox;
    logic [K_WIDTH-1:0]    ky, kx;
    logic [C_WIDTH-1:0]    cc;

    logic c_last, kx_last, ky_last, ox_last, oy_last;
    logic last_win_cur, last_all_cur;
    logic [SW-1:0]         iy_u, ix_u;
    logic                  in_bounds;
    logic [ADDR_WIDTH-1:0] pix, rd_addr_calc;

    logic                  issue, pop, accept;
    logic [1:0]            count_after;

    logic [DATA_WIDTH-1:0] mem_data [2];
    logic [1:0]            mem_pad, mem_lw, mem_la;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_count;
    logic                  cap_pend, cap_slot, head_pending;

    assign c_last       = (cc == c_words_r - C_WIDTH'(1));
    assign kx_last      = (kx == k_r - K_WIDTH'(1));
    assign ky_last      = (ky == k_r - K_WIDTH'(1));
    assign ox_last      = (ox == o_size_r - ADDR_WIDTH'(1));
    assign oy_last      = (oy == o_size_r - ADDR_WIDTH'(1));
    assign last_win_cur = c_last && kx_last && ky_last;
    assign last_all_cur = last_win_cur && ox_last && oy_last;

    assign iy_u = SW'(oy) * SW'(stride_r) + SW'(ky) - SW'(pad_r);
    assign ix_u = SW'(ox) * SW'(stride_r) + SW'(kx) - SW'(pad_r);
    assign in_bounds = !iy_u[SW-1] && !ix_u[SW-1] &&
                       (iy_u < SW'(i_size_r)) && (ix_u < SW'(i_size_r));
    // Low-bit arithmetic is enough: the address wraps modulo 2^ADDR_WIDTH anyway.
    assign pix          = iy_u[ADDR_WIDTH-1:0] * i_size_r + ix_u[ADDR_WIDTH-1:0];
    assign rd_addr_calc = start_r + pix * ADDR_WIDTH'(c_words_r) + ADDR_WIDTH'(cc);

    assign accept      = (state == S_IDLE) && i_start && !i_reg_clear;
    assign pop         = o_valid && i_ready;
    assign count_after = fifo_count - {1'b0, pop};

    // Next-state and issue decision; clear wins over everything.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_o_size == '0 || i_k_size == '0 || i_c_words == '0)
                        state_next = S_DONE;
                    else
                        state_next = S_RUN;
                end
            end
            S_RUN: begin
                issue = (fifo_count < 2'd2);
                if (issue && last_all_cur) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (count_after == 2'd0) state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (i_reg_clear) begin
            state_next = S_IDLE;
            issue      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= S_IDLE;
        else         state <= state_next;
    end

    // Config capture on start acceptance and loop-nest counters.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            start_r   <= '0;
            i_size_r  <= '0;
            o_size_r  <= '0;
            k_r       <= '0;
            stride_r  <= '0;
            pad_r     <= '0;
            c_words_r <= '0;
            oy <= '0; ox <= '0; ky <= '0; kx <= '0; cc <= '0;
        end else if (i_reg_clear) begin
            oy <= '0; ox <= '0; ky <= '0; kx <= '0; cc <= '0;
        end else if (accept) begin
            start_r   <= i_start_addr;
            i_size_r  <= i_i_size;
            o_size_r  <= i_o_size;
            k_r       <= i_k_size;
            stride_r  <= i_stride;
            pad_r     <= i_pad;
            c_words_r <= i_c_words;
            oy <= '0; ox <= '0; ky <= '0; kx <= '0; cc <= '0;
        end else if (issue) begin
            if (!c_last) cc <= cc + C_WIDTH'(1);
            else begin
                cc <= '0;
                if (!kx_last) kx <= kx + K_WIDTH'(1);
                else begin
                    kx <= '0;
                    if (!ky_last) ky <= ky + K_WIDTH'(1);
                    else begin
                        ky <= '0;
                        if (!ox_last) ox <= ox + ADDR_WIDTH'(1);
                        else begin
                            ox <= '0;
                            oy <= oy + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    // Output FIFO: tags are written at issue, read data is captured the cycle after
    // into the same slot; until then the head forwards i_rd_data directly.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < 2; i++) mem_data[i] <= '0;
            mem_pad    <= '0;
            mem_lw     <= '0;
            mem_la     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            cap_pend   <= 1'b0;
            cap_slot   <= 1'b0;
        end else if (i_reg_clear) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            cap_pend   <= 1'b0;
        end else begin
            if (issue) begin
                mem_pad[wr_ptr] <= !in_bounds;
                mem_lw[wr_ptr]  <= last_win_cur;
                mem_la[wr_ptr]  <= last_all_cur;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, issue} - {1'b0, pop};
            cap_pend   <= o_rd_en;
            cap_slot   <= wr_ptr;
            if (cap_pend) mem_data[cap_slot] <= i_rd_data;
        end
    end

    assign head_pending = cap_pend && (cap_slot == rd_ptr);

    assign o_rd_en    = issue && in_bounds;
    assign o_rd_addr  = o_rd_en ? rd_addr_calc : '0;
    assign o_valid    = (fifo_count != 2'd0);
    assign o_data     = (o_valid && !mem_pad[rd_ptr]) ?
                        (head_pending ? i_rd_data : mem_data[rd_ptr]) : '0;
    assign o_last_win = o_valid && mem_lw[rd_ptr];
    assign o_last_all = o_valid && mem_la[rd_ptr];
    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);

endmodule

// File: doc/conv_window_router.md
Name: conv_window_router

Overview:
- Sequential im2col router between the input-activation SRAM and the PE array.
- Walks a KxK convolution window with programmable stride, zero padding and multi-word channel depth over a feature map stored row-major in SRAM.
- Emits one SRAM word per element on a valid/ready stream, in window order, with window/frame markers.
- Successor to the fixed 3x3, pad-free, single-word-per-pixel sequential router.

Parameters:
DATA_WIDTH, 64, SRAM word / output element width
ADDR_WIDTH, 8, SRAM address width; also width of size/start config fields
K_WIDTH, 3, width of kernel-size field (K up to 7)
C_WIDTH, 4, width of channel-words-per-pixel field

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_reg_clear  in  1  synchronous abort/flush
i_start  in  1  start pulse; sampled only in IDLE
i_start_addr  in  ADDR_WIDTH  SRAM address of pixel (0,0), channel word 0
i_i_size  in  ADDR_WIDTH  input feature-map height = width
i_o_size  in  ADDR_WIDTH  output feature-map height = width (caller-computed)
i_k_size  in  K_WIDTH  kernel size K
i_stride  in  2  stride, 1..3
i_pad  in  2  zero padding on each side, 0..3
i_c_words  in  C_WIDTH  SRAM words per pixel C (channel groups)
o_rd_en  out  1  SRAM read enable
o_rd_addr  out  ADDR_WIDTH  SRAM read address
i_rd_data  in  DATA_WIDTH  SRAM read data; valid exactly one cycle after o_rd_en
o_valid  out  1  output element valid
i_ready  in  1  consumer ready
o_data  out  DATA_WIDTH  element word; all-zero for padded positions
o_last_win  out  1  element is last of its window
o_last_all  out  1  element is last of the whole frame
o_busy  out  1  high from start acceptance until DONE
o_done  out  1  one-cycle pulse after final element is handed off

Behaviour:
- Reset (async, i_nrst=0): state IDLE, all counters/FIFO cleared; o_rd_en, o_rd_addr, o_valid, o_data, o_last_win, o_last_all, o_busy and o_done are all 0.
- Config is latched on i_start in IDLE. Config inputs are don't-care afterwards.
- i_start while busy is ignored.
- States:
  - IDLE -> RUN on i_start.
  - IDLE -> DONE directly if latched o_size==0, K==0 or C==0. No elements are emitted in that case.
  - RUN -> DRAIN after the final element is issued.
  - DRAIN -> DONE when the FIFO is empty and nothing is in flight.
  - DONE -> IDLE after 1 cycle; o_done=1 in DONE only.
- Loop nest, outermost first: oy, ox (0..o_size-1), ky, kx (0..K-1), c (0..C-1).
  - Elements per window = K*K*C.
  - Total elements = o_size^2*K*K*C.
- Address arithmetic:
  - iy = oy*stride+ky-pad, ix = ox*stride+kx-pad, both computed signed in ADDR_WIDTH+3 bits.
  - In-bounds means 0<=iy<i_size and 0<=ix<i_size.
  - In-bounds: o_rd_addr = start + (iy*i_size+ix)*C + c, truncated modulo 2^ADDR_WIDTH (wraps silently).
  - Out-of-bounds: no read issued; a zero word is queued instead.
- Issue:
  - In RUN, one element is issued per cycle when (fifo_count + inflight) < 2.
  - Each issued element (read or pad) enters the 2-entry output FIFO exactly 1 cycle later, together with its last_win/last_all tags, preserving order.
- Output:
  - o_valid = FIFO non-empty; a pop occurs on o_valid && i_ready.
  - o_data and the tags are stable while o_valid && !i_ready.
  - First o_valid is 2 cycles after the i_start cycle.
  - With i_ready held high, throughput is 1 element/cycle with no bubbles.
- o_done asserts the cycle after the pop of the o_last_all element (via DRAIN->DONE).
- i_reg_clear (any state): next cycle IDLE, FIFO and in-flight entries discarded, o_valid=0, no o_done pulse. It has priority over i_start in the same cycle.
- Reset or clear mid-frame leaves no residual state. A subsequent i_start produces a full, correct frame.

Test Plan:
- 5x5 map, K=3, s=1, pad=0, C=1, start=0, ready=1 -> 81 elements.
  - First window addresses 0,1,2,5,6,7,10,11,12.
  - o_last_win on every 9th element; o_last_all on the 81st.
  - o_done 1 cycle after the last pop.
- Same map with pad=1, o_size=5 -> window 0 = 0,0,0,0,m[0],m[1],0,m[5],m[6] (no o_rd_en for the zeros); 225 elements total.
- i_size=5, K=3, s=2, C=2, o_size=2, start=16 -> window (0,1) first addresses 20,21,22,23; 72 elements total.
- Run 1 with i_ready toggled by a pseudo-random pattern -> identical element sequence.
  - o_data held stable while stalled; never more than 2 outstanding.
- i_reg_clear after the 10th pop, then a restart -> no o_done from the aborted frame; restarted frame matches run 1.
- o_size=0 -> o_busy for 1 cycle, o_done pulse, no o_valid, no o_rd_en.
  - i_nrst low mid-RUN -> all outputs 0 immediately.
